counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
- Controller that sequences the 8-bit loadable up-counter (sync load/enable, async active-low reset). It drives the counter's LOAD, ENA and DATA inputs and watches its CNT output.
- Each run loads a start value, counts up to an end value (wrap-around allowed) and repeats for a programmed number of passes, then signals completion.
- Sits between the lab's control logic and the counter. The controller is the only master of the counter's LOAD and ENA.

Parameters:
- WIDTH, 8, counter data width (START_VAL, END_VAL, CNT_IN, CNT_DATA)
- REP_W, 4, width of the pass-count fields REPS and PASS_CNT

Ports:
- CLK  input  1  system clock, rising edge
- RST  input  1  asynchronous, active-low reset
- START  input  1  start request; sampled only in IDLE
- STOP  input  1  abort request; sampled in any state
- START_VAL  input  WIDTH  value loaded into the counter at the start of each pass
- END_VAL  input  WIDTH  count value that terminates a pass
- REPS  input  REP_W  number of passes; 0 = run until STOP
- CNT_IN  input  WIDTH  counter's current CNT output
- CNT_LOAD  output  1  drives the counter's LOAD
- CNT_ENA  output  1  drives the counter's ENA
- CNT_DATA  output  WIDTH  drives the counter's DATA
- BUSY  output  1  high in every state except IDLE
- DONE  output  1  one-cycle pulse on normal completion
- PASS_CNT  output  REP_W  number of completed passes in the current run
- FAULT  output  1  watchdog fault flag (see Optional Feature)

Behaviour:
- Reset (RST=0, asynchronous):
  - State goes to IDLE.
  - All outputs are 0, including CNT_DATA and PASS_CNT.
  - The latched start/end/reps registers are cleared to 0.
- States: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If START=1 and STOP=0 at an edge: latch START_VAL, END_VAL and REPS; clear PASS_CNT and FAULT; go to LOAD.
  - If START and STOP are both 1, STOP wins and the state stays IDLE.
- LOAD:
  - Drives CNT_LOAD=1, CNT_ENA=1, CNT_DATA=latched start for exactly one cycle.
  - The counter loads at the next edge; the state goes to RUN.
- RUN:
  - CNT_LOAD=0.
  - CNT_ENA = (CNT_IN != latched end). This is a Mealy output, so the counter never steps past END.
  - When CNT_IN == latched end at an edge, PASS_CNT increments.
  - Next state after a match:
    - DONE if REPS != 0 and the new PASS_CNT == REPS.
    - Otherwise LOAD, which starts the next pass.
- DONE: DONE=1 and BUSY=1 for one cycle, then IDLE.
- CNT_DATA holds the latched start value at all times after the first START.
- PASS_CNT holds its final value in IDLE until the next START.
- PASS_CNT is modulo 2^REP_W; it wraps when REPS=0 (continuous mode).
- Wrap-around: if END_VAL < START_VAL, the controller waits while the counter rolls 255->0. No special handling is needed.
- END_VAL == START_VAL: the match occurs in the first RUN cycle, giving a zero-length pass (LOAD+RUN = 2 cycles per pass).
- STOP=1 in LOAD, RUN or DONE: next state is IDLE, CNT_ENA/CNT_LOAD go low immediately after that edge, and no DONE pulse is issued.
- START while BUSY is ignored, and the latched values are unchanged.
- Latency for a pass of N increments: N+2 cycles (1 LOAD, N counting, 1 match).
- A reset mid-run aborts with no DONE; all outputs return to their reset values.

Optional Feature:
- Macro: COUNTER_SEQ_WATCHDOG_EN.
- Defined:
  - A 9-bit cycle counter clears on entry to RUN and increments each RUN cycle without a match.
  - When it reaches 256 (the counter failed to advance, e.g. held in reset), the next state is IDLE and FAULT=1.
  - FAULT is sticky until the next accepted START or RST.
  - No DONE pulse is issued on a fault.
- Undefined: no watchdog logic is built, and FAULT is tied to 0.

Test Plan:
- START_VAL=5, END_VAL=9, REPS=2, START pulsed at edge 0 -> CNT sequence 5,6,7,8,9 twice; PASS_CNT 1 then 2; DONE high for the single cycle after edge 12; BUSY low after edge 13.
- START_VAL=250, END_VAL=2, REPS=1 -> CNT 250..255,0,1,2; CNT_ENA low while CNT=2; DONE in the cycle after edge 10; PASS_CNT=1.
- START_VAL=END_VAL=7, REPS=3 -> CNT_ENA never high in RUN; CNT stays 7; DONE after edge 6; PASS_CNT=3.
- REPS=0, START_VAL=0, END_VAL=3 -> passes repeat indefinitely with PASS_CNT incrementing; STOP at CNT=2 -> IDLE next edge, CNT frozen at 2 or 3, no DONE pulse.
- RST driven low mid-RUN (CNT=6) -> all outputs 0 asynchronously; START with START=STOP=1 -> stays IDLE.
- With COUNTER_SEQ_WATCHDOG_EN defined, counter held in reset (CNT_IN=0), END_VAL=9 -> FAULT=1 and BUSY=0 after 256 RUN cycles; the next START clears FAULT.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer: sequences an external 8-bit loadable up-counter.
// Each run loads START_VAL, lets the counter climb to END_VAL (wrapping
// through 255->0 if needed), and repeats for REPS passes (REPS=0 means
// run until STOP).
// Handshake: START is taken only while BUSY=0 (and STOP=0). BUSY stays high
// from the edge that accepts START until the run ends. A normal end is
// marked by a single-cycle DONE while BUSY is still high. An abort (STOP,
// reset or watchdog) ends with BUSY falling and no DONE.
// Optional watchdog: define COUNTER_SEQ_WATCHDOG_EN to abort a pass that
// sees no END match within 256 RUN cycles and raise a sticky FAULT.
// dbg_state exposes the FSM state for debug.
module counter_sequencer #(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic [WIDTH-1:0] START_VAL,
  input  logic [WIDTH-1:0] END_VAL,
  input  logic [REP_W-1:0] REPS,
  input  logic [WIDTH-1:0] CNT_IN,
  output logic             CNT_LOAD,
  output logic             CNT_ENA,
  output logic [WIDTH-1:0] CNT_DATA,
  output logic             BUSY,
  output logic             DONE,
  output logic [REP_W-1:0] PASS_CNT,
  output logic             FAULT,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] end_q, end_d;
  logic [REP_W-1:0] reps_q, reps_d;
  logic [REP_W-1:0] pass_q, pass_d;
  logic [REP_W-1:0] pass_inc;
  logic             match;

`ifdef COUNTER_SEQ_WATCHDOG_EN
  logic [8:0]       wd_q, wd_d;
  logic [8:0]       wd_inc;
  logic             fault_q, fault_d;
`endif

  // The pass ends when the counter shows the latched end value.
  assign match    = (CNT_IN == end_q);
  assign pass_inc = pass_q + 1'b1;

`ifdef COUNTER_SEQ_WATCHDOG_EN
  assign wd_inc   = wd_q + 9'd1;
`endif

  // Next-state and output decode; CNT_ENA in RUN is Mealy so the counter
  // is frozen in the very cycle it presents the end value.
  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    end_d    = end_q;
    reps_d   = reps_q;
    pass_d   = pass_q;
    CNT_LOAD = 1'b0;
    CNT_ENA  = 1'b0;
    DONE     = 1'b0;
`ifdef COUNTER_SEQ_WATCHDOG_EN
    wd_d     = wd_q;
    fault_d  = fault_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (START && !STOP) begin
          start_d = START_VAL;
          end_d   = END_VAL;
          reps_d  = REPS;
          pass_d  = '0;
`ifdef COUNTER_SEQ_WATCHDOG_EN
          fault_d = 1'b0;
`endif
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        CNT_LOAD = 1'b1;
        CNT_ENA  = 1'b1;
`ifdef COUNTER_SEQ_WATCHDOG_EN
        wd_d     = '0;
`endif
        state_d  = STOP ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        CNT_ENA = !match;
        if (match) begin
          pass_d = pass_inc;
          if ((reps_q != '0) && (pass_inc == reps_q)) state_d = S_DONE;
          else                                        state_d = S_LOAD;
        end
`ifdef COUNTER_SEQ_WATCHDOG_EN
        else begin
          wd_d = wd_inc;
          if (wd_inc == 9'd256) begin
            state_d = S_IDLE;
            fault_d = 1'b1;
          end
        end
`endif
        if (STOP) state_d = S_IDLE;
      end
      S_DONE: begin
        DONE    = !STOP;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latched run parameters; everything clears on reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      start_q <= '0;
      end_q   <= '0;
      reps_q  <= '0;
      pass_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      end_q   <= end_d;
      reps_q  <= reps_d;
      pass_q  <= pass_d;
    end
  end

`ifdef COUNTER_SEQ_WATCHDOG_EN
  // Watchdog cycle counter and sticky fault flag.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wd_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      fault_q <= fault_d;
    end
  end

  assign FAULT = fault_q;
`else
  assign FAULT = 1'b0;
`endif

  assign BUSY      = (state_q != S_IDLE);
  assign CNT_DATA  = start_q;
  assign PASS_CNT  = pass_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: a behavioural counter drives CNT_IN, each
// run's outcome is predicted from pass arithmetic, and a monitor compares
// the DUT's state at the end of every busy period against the prediction.
module tb_counter_sequencer;

  localparam int RW = 39;  // {fault, done[1:0], pass[3:0], cnt[7:0], data[7:0], cycles[15:0]}

  logic       CLK;
  logic       RST;
  logic       START;
  logic       STOP;
  logic [7:0] START_VAL;
  logic [7:0] END_VAL;
  logic [3:0] REPS;
  logic [7:0] cnt;
  logic       CNT_LOAD;
  logic       CNT_ENA;
  logic [7:0] CNT_DATA;
  logic       BUSY;
  logic       DONE;
  logic [3:0] PASS_CNT;
  logic       FAULT;
  logic [1:0] dbg_state;
  logic       hold_cnt;

  int vectors;
  int errors;
  logic [RW-1:0] exp_q[$];

  counter_sequencer #(.WIDTH(8), .REP_W(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP),
    .START_VAL(START_VAL), .END_VAL(END_VAL), .REPS(REPS),
    .CNT_IN(cnt), .CNT_LOAD(CNT_LOAD), .CNT_ENA(CNT_ENA),
    .CNT_DATA(CNT_DATA), .BUSY(BUSY), .DONE(DONE),
    .PASS_CNT(PASS_CNT), .FAULT(FAULT), .dbg_state(dbg_state)
  );

  // Clock
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural loadable up-counter; hold_cnt models it being held in reset.
  always @(posedge CLK) begin
    if (hold_cnt)     cnt <= 8'd0;
    else if (CNT_ENA) cnt <= CNT_LOAD ? CNT_DATA : cnt + 8'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Outcome of a run: a pass of n increments takes n+2 cycles (LOAD, n
  // counting cycles, match cycle); a normal run adds one DONE cycle.
  // stop_t is the edge (counted from the START edge) at which STOP is seen.
  function automatic logic [RW-1:0] model(input logic [7:0] s, input logic [7:0] e,
                                          input logic [3:0] r, input int stop_t);
    int n, len, t_end, passes, r_pos, cnt_v, done_v;
    n   = (int'(e) - int'(s)) & 255;
    len = n + 2;
    if (stop_t == 0) begin
      t_end  = int'(r) * len + 1;
      passes = int'(r);
      cnt_v  = int'(e);
      done_v = 1;
    end else begin
      t_end  = stop_t;
      r_pos  = (stop_t - 1) % len;
      passes = (stop_t - 1) / len;
      done_v = 0;
      if (r_pos == 0)      cnt_v = int'(s);
      else if (r_pos - 1 < n) cnt_v = (int'(s) + r_pos) & 255;
      else begin
        cnt_v  = int'(e);
        passes = passes + 1;
      end
    end
    model = {1'b0, done_v[1:0], passes[3:0], cnt_v[7:0], s, t_end[15:0]};
  endfunction

  // Issue START at edge 0, then keep driving for t_end+2 edges: noise on the
  // parameter inputs, stray START pulses while busy, STOP at edge stop_t.
  task automatic drive(input logic [7:0] s, input logic [7:0] e, input logic [3:0] r,
                       input int stop_t, input int t_end);
    START_VAL = s;
    END_VAL   = e;
    REPS      = r;
    STOP      = 1'b0;
    START     = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    for (int k = 1; k <= t_end + 2; k++) begin
      START_VAL = 8'($urandom);
      END_VAL   = 8'($urandom);
      REPS      = 4'($urandom);
      START     = (k < t_end) && ($urandom_range(0, 3) == 0);
      STOP      = (k == stop_t);
      @(posedge CLK); #1;
    end
    START = 1'b0;
    STOP  = 1'b0;
  endtask

  task automatic run(input logic [7:0] s, input logic [7:0] e, input logic [3:0] r,
                     input int stop_t);
    int len, t_end;
    len   = ((int'(e) - int'(s)) & 255) + 2;
    t_end = (stop_t != 0) ? stop_t : int'(r) * len + 1;
    exp_q.push_back(model(s, e, r, stop_t));
    drive(s, e, r, stop_t, t_end);
  endtask

  // Monitor: when BUSY falls, compare the observed run outcome with the
  // oldest prediction.
  initial begin : monitor
    int busy_cyc;
    int done_cnt;
    logic prev_busy;
    logic [RW-1:0] act;
    logic [RW-1:0] exp;
    busy_cyc  = 0;
    done_cnt  = 0;
    prev_busy = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        busy_cyc  = 0;
        done_cnt  = 0;
        prev_busy = 1'b0;
      end else begin
        if (BUSY) begin
          busy_cyc++;
          if (DONE && done_cnt < 3) done_cnt++;
        end else if (prev_busy) begin
          act = {FAULT, done_cnt[1:0], PASS_CNT, cnt, CNT_DATA, busy_cyc[15:0]};
          vectors++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL run_end unexpected: actual=%h required=none", act);
          end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
              errors++;
              $display("FAIL run_end actual fault=%0d done=%0d pass=%0d cnt=%0d data=%0d cyc=%0d required fault=%0d done=%0d pass=%0d cnt=%0d data=%0d cyc=%0d",
                       act[38], act[37:36], act[35:32], act[31:24], act[23:16], act[15:0],
                       exp[38], exp[37:36], exp[35:32], exp[31:24], exp[23:16], exp[15:0]);
            end
          end
          busy_cyc = 0;
          done_cnt = 0;
        end
        prev_busy = BUSY;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load"},  64'(CNT_LOAD), 64'd0);
    check({tag, "_ena"},   64'(CNT_ENA),  64'd0);
    check({tag, "_data"},  64'(CNT_DATA), 64'd0);
    check({tag, "_busy"},  64'(BUSY),     64'd0);
    check({tag, "_done"},  64'(DONE),     64'd0);
    check({tag, "_pass"},  64'(PASS_CNT), 64'd0);
    check({tag, "_fault"}, 64'(FAULT),    64'd0);
  endtask

  // Stimulus
  initial begin : driver
    logic [7:0] s, e;
    logic [3:0] r;
    int len, stop_t;
    vectors   = 0;
    errors    = 0;
    hold_cnt  = 1'b0;
    RST       = 1'b0;
    START     = 1'b0;
    STOP      = 1'b0;
    START_VAL = 8'd0;
    END_VAL   = 8'd0;
    REPS      = 4'd0;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;

    // Directed runs
    run(8'd5,   8'd9,   4'd2, 0);   // two passes 5..9
    run(8'd250, 8'd2,   4'd1, 0);   // wrap through 255->0
    run(8'd7,   8'd7,   4'd3, 0);   // zero-length passes
    run(8'd0,   8'd3,   4'd0, 14);  // continuous, STOP while CNT=2
    run(8'd0,   8'd0,   4'd0, 81);  // continuous, PASS_CNT wraps past 15
    run(8'd10,  8'd14,  4'd2, 12);  // STOP on the final match: no DONE
    run(8'd33,  8'd40,  4'd15, 0);  // maximum pass count

    // Random runs
    repeat (20) begin
      s   = 8'($urandom_range(0, 255));
      e   = s + 8'($urandom_range(0, 30));
      r   = 4'($urandom_range(0, 4));
      len = ((int'(e) - int'(s)) & 255) + 2;
      if (r == 4'd0)                      stop_t = $urandom_range(1, 3 * len + 5);
      else if ($urandom_range(0, 3) == 0) stop_t = $urandom_range(1, int'(r) * len);
      else                                stop_t = 0;
      run(s, e, r, stop_t);
    end

    // Reset in the middle of a run (CNT=6)
    START_VAL = 8'd0;
    END_VAL   = 8'd20;
    REPS      = 4'd1;
    START     = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    repeat (7) @(posedge CLK);
    #1 RST = 1'b0;
    #1;
    check_reset_outputs("midrun_reset");
    @(posedge CLK); #1 RST = 1'b1;
    @(posedge CLK); #1;

    // START with STOP in IDLE is refused
    START_VAL = 8'd44;
    START     = 1'b1;
    STOP      = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    STOP  = 1'b0;
    check("start_stop_busy", 64'(BUSY),     64'd0);
    check("start_stop_load", 64'(CNT_LOAD), 64'd0);
    check("start_stop_data", 64'(CNT_DATA), 64'd0);
    @(posedge CLK); #1;

    // Recovery after reset
    run(8'd100, 8'd120, 4'd1, 0);

`ifdef COUNTER_SEQ_WATCHDOG_EN
    // Counter stuck at 0: 1 LOAD cycle + 256 RUN cycles, then fault
    hold_cnt = 1'b1;
    exp_q.push_back({1'b1, 2'd0, 4'd0, 8'd0, 8'd5, 16'd257});
    drive(8'd5, 8'd9, 4'd1, 0, 257);
    hold_cnt = 1'b0;
    check("wd_fault_sticky", 64'(FAULT), 64'd1);
    run(8'd5, 8'd9, 4'd1, 0);      // next START clears FAULT
`endif

    repeat (4) @(posedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
